// File: rtl/uart_pkg.sv
// Shared definitions for the push-button driven UART transmit path.
// Purpose: trigger FSM state encoding, ASCII sequence limits, sequence-step helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
package uart_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = IDLE,
    ST_SEND      = SEND,
    ST_WAIT_DONE = WAIT_DONE
  } state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  // Next byte of the wrapping sequence.
  function automatic logic [7:0] next_seq(input logic [7:0] cur,
                                          input logic [7:0] first,
                                          input logic [7:0] last);
    return (cur == last) ? first : cur + 8'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button input.
// Latency: din rise -> level rise 2 + DEBOUNCE_CYCLES cycles, rise_pulse one cycle later.
// Backpressure: none; free-running.
// Ports: Clk/Rst (sync, active high); din raw async input; level debounced level;
//        rise_pulse one-cycle pulse the cycle after level goes 0->1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic din,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      rise_pulse <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_a     <= din;
      sync_b     <= sync_a;
      level_q    <= level;
      // Registered edge detect: pulse lands the cycle after level rises.
      rise_pulse <= level & ~level_q;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Input has differed for DEBOUNCE_CYCLES consecutive samples.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_tx_trigger.sv
// Turns debounced button presses into one-cycle UART requests carrying '0'..'9'.
// Latency: button_in rise -> btn_press 2+DEBOUNCE_CYCLES+1 cycles, TxEn one cycle later.
// Backpressure: waits for TxDone (or watchdog); one press queued, further presses dropped.
// Ports: Clk/Rst (sync, active high); button_in raw button; TxDone transmitter done
//        (rising edge); TxEn/TxByte request and byte; btn_level/btn_press debounce
//        status; pending queued press; tx_err sticky watchdog flag.
module button_tx_trigger
  import uart_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 5000,
  parameter int         TIMEOUT_CYCLES  = 2000000,
  parameter logic [7:0] FIRST_BYTE      = ASCII_0,
  parameter logic [7:0] LAST_BYTE       = ASCII_9
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       button_in,
  input  logic       TxDone,
  output logic       TxEn,
  output logic [7:0] TxByte,
  output logic       btn_level,
  output logic       btn_press,
  output logic       pending,
  output logic       tx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic          txdone_q;
  logic          done;
  logic [7:0]    seq;
  logic [TW-1:0] tcnt;

  logic start;        // IDLE -> SEND: latch byte, consume any queued press
  logic advance;      // leaving SEND: step sequence, arm watchdog
  logic queue_press;  // press seen while busy
  logic set_err;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk       (Clk),
    .Rst       (Rst),
    .din       (button_in),
    .level     (btn_level),
    .rise_pulse(btn_press)
  );

  // A TxDone held high only counts once.
  assign done = TxDone & ~txdone_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    TxEn        = 1'b0;
    start       = 1'b0;
    advance     = 1'b0;
    queue_press = 1'b0;
    set_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A new press and a queued press together yield a single send.
        if (btn_press || pending) begin
          start     = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        TxEn        = 1'b1;
        advance     = 1'b1;
        queue_press = btn_press;
        state_nxt   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        queue_press = btn_press;
        if (done) begin
          state_nxt = ST_IDLE;
        end else if (tcnt == TCNT_LAST) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      txdone_q <= 1'b0;
      TxByte   <= FIRST_BYTE;
      seq      <= FIRST_BYTE;
      pending  <= 1'b0;
      tcnt     <= '0;
      tx_err   <= 1'b0;
    end else begin
      txdone_q <= TxDone;
      if (start) begin
        TxByte  <= seq;
        pending <= 1'b0;
      end else if (queue_press) begin
        // Already-pending presses fall through here with no change.
        pending <= 1'b1;
      end
      if (advance) begin
        seq  <= next_seq(seq, FIRST_BYTE, LAST_BYTE);
        tcnt <= '0;
      end else if (state == ST_WAIT_DONE) begin
        tcnt <= tcnt + TW'(1);
      end
      if (set_err) begin
        tx_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_tx_trigger.sv
// Testbench for button_tx_trigger with short debounce/timeout settings.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// before new inputs are applied, so a sample at loop step k shows cycle k.
module tb_button_tx_trigger;

  localparam int DB = 8;
  localparam int TO = 64;
  localparam int PRESS_LAT = 2 + DB + 1;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       button_in = 1'b0;
  logic       TxDone = 1'b0;
  logic       TxEn;
  logic [7:0] TxByte;
  logic       btn_level;
  logic       btn_press;
  logic       pending;
  logic       tx_err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_seq  = 0;

  typedef struct {
    int width;
    int done_dly;
    int exp_press;
  } vec_t;

  vec_t vecs [15];

  always #5 Clk = ~Clk;

  button_tx_trigger #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .FIRST_BYTE     (8'h30),
    .LAST_BYTE      (8'h39)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .button_in(button_in),
    .TxDone   (TxDone),
    .TxEn     (TxEn),
    .TxByte   (TxByte),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .pending  (pending),
    .tx_err   (tx_err)
  );

  function automatic int exp_byte(input int n);
    return 32'h30 + (n % 10);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; button_in = 1'b0; TxDone = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_txen",    int'(TxEn), 0);
    check("rst_txbyte",  int'(TxByte), 32'h30);
    check("rst_level",   int'(btn_level), 0);
    check("rst_press",   int'(btn_press), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_txerr",   int'(tx_err), 0);
    Rst = 1'b0;
    exp_seq = 0;
  endtask

  // One button pulse of 'width' cycles from idle; acknowledges any request.
  task automatic run_pulse(input int width, input int done_dly, input int exp_press);
    int npress, lat, nlvl, ntx, tx_cyc, done_cyc;
    npress = 0; lat = -1; nlvl = 0; ntx = 0; tx_cyc = -1; done_cyc = -1;
    for (int k = 0; k < 70; k++) begin
      @(negedge Clk);
      if (btn_press) begin
        npress++;
        if (lat < 0) lat = k;
      end
      if (btn_level) nlvl++;
      if (TxEn) begin
        ntx++;
        if (tx_cyc < 0) tx_cyc = k;
        check("vec_txbyte", int'(TxByte), exp_byte(exp_seq));
        exp_seq++;
        done_cyc = k + done_dly;
      end
      button_in = (k < width);
      TxDone    = (k == done_cyc);
    end
    check("vec_npress", npress, exp_press);
    check("vec_ntx", ntx, exp_press);
    check("vec_level_cycles", nlvl, (exp_press > 0) ? width : 0);
    if (exp_press > 0) begin
      check("vec_press_lat", lat, PRESS_LAT);
      check("vec_txen_lat", tx_cyc, PRESS_LAT + 1);
    end
  endtask

  task automatic run_bounce();
    int npress, ntx, nlvl;
    npress = 0; ntx = 0; nlvl = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge Clk);
      if (btn_press) npress++;
      if (TxEn) ntx++;
      if (btn_level) nlvl++;
      button_in = (k < 30) ? (((k / 3) % 2) == 0) : 1'b0;
    end
    check("bounce_npress", npress, 0);
    check("bounce_ntx", ntx, 0);
    check("bounce_level", nlvl, 0);
  endtask

  task automatic run_queue();
    int ntx, npress, tx2_cyc;
    ntx = 0; npress = 0; tx2_cyc = -1;
    do_reset();
    for (int k = 0; k < 160; k++) begin
      @(negedge Clk);
      if (btn_press) npress++;
      if (TxEn) begin
        ntx++;
        if (ntx == 1) begin
          check("q_tx1_cyc", k, PRESS_LAT + 1);
          check("q_tx1_byte", int'(TxByte), 32'h30);
        end else if (ntx == 2) begin
          tx2_cyc = k;
          check("q_tx2_byte", int'(TxByte), 32'h31);
        end
      end
      if (k == 40) check("q_pending_set", int'(pending), 1);
      if (k == 55) check("q_pending_hold", int'(pending), 1);
      if (k == 62) check("q_pending_clr", int'(pending), 0);
      button_in = (k < 10) || (k >= 20 && k < 30) || (k >= 40 && k < 50);
      TxDone    = (k == 60) || (k == 70);
    end
    check("q_npress", npress, 3);
    check("q_ntx", ntx, 2);
    check("q_tx2_cyc", tx2_cyc, 62);
    check("q_txerr", int'(tx_err), 0);
  endtask

  task automatic run_timeout();
    int ntx, tx2_cyc;
    ntx = 0; tx2_cyc = -1;
    do_reset();
    for (int k = 0; k < 140; k++) begin
      @(negedge Clk);
      // WAIT_DONE entered at cycle 13, so the flag appears 64 cycles later.
      if (k == 76) check("to_err_before", int'(tx_err), 0);
      if (k == 77) check("to_err_set", int'(tx_err), 1);
      if (TxEn) begin
        ntx++;
        if (ntx == 2) begin
          tx2_cyc = k;
          check("to_tx2_byte", int'(TxByte), 32'h31);
        end
      end
      button_in = (k < 10) || (k >= 90 && k < 100);
      TxDone    = (k == 110);
    end
    check("to_ntx", ntx, 2);
    check("to_tx2_cyc", tx2_cyc, 90 + PRESS_LAT + 1);
    check("to_err_sticky", int'(tx_err), 1);
  endtask

  task automatic run_mid_reset();
    int ntx_after;
    ntx_after = 0;
    do_reset();
    for (int k = 0; k < 140; k++) begin
      @(negedge Clk);
      if (k == 35) check("mr_pending_before", int'(pending), 1);
      if (k == 41) begin
        check("mr_txen",    int'(TxEn), 0);
        check("mr_txbyte",  int'(TxByte), 32'h30);
        check("mr_pending", int'(pending), 0);
        check("mr_level",   int'(btn_level), 0);
        check("mr_press",   int'(btn_press), 0);
        check("mr_txerr",   int'(tx_err), 0);
      end
      if (k >= 41 && TxEn) ntx_after++;
      button_in = (k < 10) || (k >= 20 && k < 30);
      Rst       = (k == 40);
      TxDone    = 1'b0;
    end
    check("mr_no_txen", ntx_after, 0);
    exp_seq = 0;
    run_pulse(12, 5, 1);
  endtask

  // Transaction-level reference: presses arrive PRESS_LAT after each clean
  // rise; the link is busy from a send until done+1 (or send+TO+1 on a
  // watchdog expiry); one press may wait while busy, the rest are lost.
  task automatic run_random(input int ncyc);
    int pq[$];
    int bstate, brem;
    int send_at, free_at, done_at, err_from, ntx;
    bit pend, press_now, triggered;
    bstate = 0; brem = 15;
    send_at = -1; free_at = 0; done_at = -1; err_from = 1 << 30; ntx = 0;
    pend = 1'b0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
      press_now = (pq.size() > 0) && (pq[0] == c);
      if (press_now) void'(pq.pop_front());
      check("rnd_press",   int'(btn_press), int'(press_now));
      check("rnd_txen",    int'(TxEn), int'(send_at == c));
      check("rnd_pending", int'(pending), int'(pend));
      check("rnd_txerr",   int'(tx_err), int'(c >= err_from));
      if (send_at == c) begin
        if (TxEn) check("rnd_txbyte", int'(TxByte), exp_byte(ntx));
        ntx++;
        send_at = -1;
        if ($urandom_range(7) == 0) begin
          done_at = -1;
          free_at = c + TO + 1;
          if (err_from > free_at) err_from = free_at;
        end else begin
          done_at = c + int'($urandom_range(40, 1));
          free_at = done_at + 1;
        end
      end
      triggered = 1'b0;
      if (c >= free_at && pend) begin
        send_at   = c + 1;
        pend      = 1'b0;
        triggered = 1'b1;
      end
      if (press_now) begin
        if (c >= free_at) begin
          if (!triggered) send_at = c + 1;
        end else if (!pend) begin
          pend = 1'b1;
        end
      end
      if (brem == 0) begin
        bstate = 1 - bstate;
        brem   = (bstate == 1) ? int'($urandom_range(20, 10)) : int'($urandom_range(40, 12));
        if (bstate == 1) pq.push_back(c + PRESS_LAT);
      end
      brem--;
      button_in = (bstate == 1);
      TxDone    = (c == done_at);
    end
    check("rnd_sent_some", int'(ntx > 20), 1);
  endtask

  initial begin
    vecs = '{'{1, 5, 0}, '{3, 5, 0}, '{7, 5, 0}, '{20, 5, 1}, '{8, 10, 1},
             '{9, 20, 1}, '{12, 20, 1}, '{12, 20, 1}, '{12, 20, 1}, '{12, 20, 1},
             '{12, 20, 1}, '{12, 20, 1}, '{12, 20, 1}, '{12, 20, 1}, '{12, 20, 1}};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_pulse(vecs[i].width, vecs[i].done_dly, vecs[i].exp_press);
    end
    check("wrap_count", exp_seq, 12);
    run_bounce();
    run_queue();
    run_timeout();
    run_mid_reset();
    run_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/button_tx_trigger.md
Name: button_tx_trigger

Overview:
- Upstream stage of the UART transmitter in TOP.
- Synchronises and debounces the raw push-button, then turns each accepted press into a one-cycle TxEn request carrying a sequence byte ('0'..'9' ASCII, wrapping).
- Holds the request until the transmitter reports TxDone. Presses arriving mid-transfer are queued one deep; a watchdog recovers from a missing TxDone.

Parameters:
- DEBOUNCE_CYCLES, 5000: stable-input cycles required before a level change is accepted (50 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: max cycles to wait for TxDone after TxEn.
- FIRST_BYTE, 8'h30: byte sent on the first press after reset.
- LAST_BYTE, 8'h39: after this byte is sent, the next byte is FIRST_BYTE.

Ports:
- Clk  in  1  system clock, 100 MHz.
- Rst  in  1  synchronous, active-high reset.
- button_in  in  1  raw asynchronous button, active high.
- TxDone  in  1  transmitter completion; a rising edge is taken as done.
- TxEn  out  1  one-cycle transmit request.
- TxByte  out  8  byte to transmit; valid while TxEn=1 and held until the next request.
- btn_level  out  1  debounced button level.
- btn_press  out  1  one-cycle pulse on each debounced 0->1 edge.
- pending  out  1  a queued press is waiting.
- tx_err  out  1  sticky flag: a TxDone timeout occurred.

Behaviour:
- Reset (Rst=1 at a Clk edge): all outputs 0 except TxByte=FIRST_BYTE. Synchroniser flops, counters, pending and FSM cleared; FSM goes to IDLE. Reset mid-transfer drops the request and any queued press; no TxEn is issued while Rst=1.
- Synchroniser: 2 flops on button_in.
- TxDone handling: TxDone is registered once; done = TxDone & ~TxDone_q. A level held high therefore counts once.
- Debounce:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever the synchronised input equals btn_level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 (the input has differed for DEBOUNCE_CYCLES consecutive cycles), btn_level toggles on the next edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
- btn_press: high for exactly the cycle after btn_level goes 0->1. Total latency from a button_in rise to btn_press is 2 sync + DEBOUNCE_CYCLES + 1 cycles. The release edge produces no pulse.
- FSM states IDLE, SEND, WAIT_DONE:
  - IDLE: on btn_press or pending=1, go to SEND. If the trigger came from pending, clear pending in the same cycle.
  - SEND (1 cycle): TxEn=1; TxByte holds the current sequence byte. Then go to WAIT_DONE, clear the timeout counter, and advance the sequence byte (LAST_BYTE -> FIRST_BYTE, otherwise +1, 8-bit).
  - WAIT_DONE:
    - On done, return to IDLE.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 without done, set tx_err=1 and return to IDLE.
    - A done seen outside WAIT_DONE is ignored.
- Queueing:
  - btn_press in SEND or WAIT_DONE sets pending=1.
  - Further presses while pending=1 are dropped, with no counter or flag change.
  - btn_press in IDLE while pending=1: a single SEND is issued and both triggers are consumed.
- Back-to-back: the minimum spacing between TxEn pulses is 3 cycles (SEND, WAIT_DONE with done, IDLE).
- tx_err is cleared only by Rst.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE=2'd0, SEND=2'd1, WAIT_DONE=2'd2) and ASCII constants ASCII_0/ASCII_9.
- One sub-module, button_debounce (Clk, Rst, din, level, rise_pulse; parameter DEBOUNCE_CYCLES). It is reusable for future buttons.
- The FSM, sequence counter and watchdog live in button_tx_trigger.

Test Plan (DEBOUNCE_CYCLES=8, TIMEOUT_CYCLES=64 for sim):
- Clean press: button_in high for 20 cycles -> btn_press exactly once, 11 cycles after the rise; TxEn=1 with TxByte=8'h30 the cycle after; btn_level falls 10 cycles after release with no pulse.
- Bounce: button_in toggling every 3 cycles for 30 cycles, then held low -> no btn_press, no TxEn, btn_level stays 0.
- Sequence wrap: 11 presses, each acknowledged by a 1-cycle TxDone pulse 20 cycles after TxEn -> TxByte 30,31,...,39,30.
- Queueing: press, then 2 more presses before TxDone -> pending=1 after the 2nd press, 3rd dropped; TxDone -> second TxEn (8'h31) 2 cycles later; no third TxEn.
- Timeout: press with TxDone held 0 -> tx_err=1 exactly 64 cycles after entering WAIT_DONE, FSM back in IDLE; next press sends 8'h31.
- Reset mid-transfer: Rst=1 for 1 cycle during WAIT_DONE with pending=1 -> all outputs 0, TxByte=8'h30, no TxEn afterwards until a new press.
